// File: rtl/counter_nbit_ud_if.sv
//------------------------------------------------------------------------------
// counter_nbit_ud_if : control/status bundle for the up/down counter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface counter_nbit_ud_if #(
   parameter int WIDTH = 32
);
   logic             ce;
   logic             s;
   logic             load;
   logic [WIDTH-1:0] pdata;
   logic             clr;
   logic [WIDTH-1:0] cnt;
   logic             rc;
   logic             tc;
   logic             ovf;

   modport master (
      output ce, s, load, pdata, clr,
      input  cnt, rc, tc, ovf
   );

   modport slave (
      input  ce, s, load, pdata, clr,
      output cnt, rc, tc, ovf
   );
endinterface

`default_nettype wire

// File: rtl/counter_nbit_ud.sv
//------------------------------------------------------------------------------
// counter_nbit_ud : N-bit up/down counter, wrap or saturate, sticky overflow.
// Optional prescaler under macro COUNTER_PRESCALE_EN.          Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module counter_nbit_ud #(
   parameter int          WIDTH      = 32,
   parameter logic [31:0] MAX_VAL    = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << WIDTH) - 32'd1),
   parameter int          SAT        = 0,
   parameter int          PRESC_BITS = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   counter_nbit_ud_if.slave     bus
);

   localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];

   if (WIDTH < 2 || WIDTH > 32 || PRESC_BITS < 1) begin : g_param_check
      $error("counter_nbit_ud: WIDTH must be 2..32 and PRESC_BITS >= 1");
   end

   logic [WIDTH-1:0] cnt_r;
   logic             rc_r;
   logic             ovf_r;
   logic             step_en;
   logic             at_top;
   logic             at_bot;
   logic             term_step;
   logic [WIDTH-1:0] cnt_step;
   logic [WIDTH-1:0] load_val;

`ifdef COUNTER_PRESCALE_EN
   logic [PRESC_BITS-1:0] presc_r;

   // Free-running; clr does not touch it, only rst.
   always_ff @(posedge clk) begin
      if (rst) presc_r <= '0;
      else     presc_r <= presc_r + 1'b1;
   end

   assign step_en = bus.ce & (&presc_r);
`else
   assign step_en = bus.ce;
`endif

   assign at_top   = (cnt_r == MAX_V);
   assign at_bot   = (cnt_r == '0);
   assign load_val = (bus.pdata > MAX_V) ? MAX_V : bus.pdata;

   always_comb begin
      term_step = step_en & (bus.s ? at_top : at_bot);
      if (bus.s) cnt_step = at_top ? ((SAT != 0) ? MAX_V : '0) : cnt_r + 1'b1;
      else       cnt_step = at_bot ? ((SAT != 0) ? '0 : MAX_V) : cnt_r - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         cnt_r <= '0;
         rc_r  <= 1'b0;
         ovf_r <= 1'b0;
      end else if (bus.load) begin
         cnt_r <= load_val;
         rc_r  <= 1'b0;
      end else if (step_en) begin
         cnt_r <= cnt_step;
         rc_r  <= term_step;
         ovf_r <= ovf_r | term_step;
      end else begin
         rc_r  <= 1'b0;
      end
   end

   assign bus.cnt = cnt_r;
   assign bus.rc  = rc_r;
   assign bus.ovf = ovf_r;
   assign bus.tc  = bus.s ? at_top : at_bot;

endmodule

`default_nettype wire

// File: tb/tb_counter_nbit_ud.sv
//------------------------------------------------------------------------------
// tb_counter_nbit_ud : wrap and saturating counters against a behavioural model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter_nbit_ud;

   localparam int MAXV = 9;
   localparam int PB   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b0, s = 1'b0, load = 1'b0, clr = 1'b0;
   logic [3:0] pdata = '0;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   counter_nbit_ud_if #(.WIDTH(4)) bw ();
   counter_nbit_ud_if #(.WIDTH(4)) bs ();

   assign bw.ce = ce;  assign bw.s = s;  assign bw.load = load;
   assign bw.pdata = pdata;  assign bw.clr = clr;
   assign bs.ce = ce;  assign bs.s = s;  assign bs.load = load;
   assign bs.pdata = pdata;  assign bs.clr = clr;

   counter_nbit_ud #(.WIDTH(4), .MAX_VAL(32'd9), .SAT(0), .PRESC_BITS(PB))
      u_wrap (.clk(clk), .rst(rst), .bus(bw));
   counter_nbit_ud #(.WIDTH(4), .MAX_VAL(32'd9), .SAT(1), .PRESC_BITS(PB))
      u_sat  (.clk(clk), .rst(rst), .bus(bs));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: index 0 wraps, index 1 saturates; values held as plain integers.
   int m_cnt [2];
   int m_rc  [2];
   int m_ovf [2];
   int m_presc;

   always @(posedge clk) begin : model
      int  nxt;
      bit  term;
      bit  step;
      step = ce;
`ifdef COUNTER_PRESCALE_EN
      step = ce && (m_presc == (1 << PB) - 1);
      m_presc <= rst ? 0 : (m_presc + 1) % (1 << PB);
`endif
      for (int k = 0; k < 2; k++) begin
         if (rst || clr) begin
            m_cnt[k] <= 0; m_rc[k] <= 0; m_ovf[k] <= 0;
         end else if (load) begin
            m_cnt[k] <= (int'(pdata) > MAXV) ? MAXV : int'(pdata);
            m_rc[k]  <= 0;
         end else if (step) begin
            nxt  = s ? m_cnt[k] + 1 : m_cnt[k] - 1;
            term = (nxt > MAXV) || (nxt < 0);
            if (term) nxt = (k == 1) ? m_cnt[k] : (nxt + MAXV + 1) % (MAXV + 1);
            m_cnt[k] <= nxt;
            m_rc[k]  <= int'(term);
            if (term) m_ovf[k] <= 1;
         end else begin
            m_rc[k] <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("wrap.cnt", int'(bw.cnt), m_cnt[0]);
         chk("wrap.rc",  int'(bw.rc),  m_rc[0]);
         chk("wrap.ovf", int'(bw.ovf), m_ovf[0]);
         chk("wrap.tc",  int'(bw.tc),  int'(s ? m_cnt[0] == MAXV : m_cnt[0] == 0));
         chk("sat.cnt",  int'(bs.cnt), m_cnt[1]);
         chk("sat.rc",   int'(bs.rc),  m_rc[1]);
         chk("sat.ovf",  int'(bs.ovf), m_ovf[1]);
         chk("sat.tc",   int'(bs.tc),  int'(s ? m_cnt[1] == MAXV : m_cnt[1] == 0));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      m_presc = 0;
      cyc();
      started = 1'b1;
      chk("reset.cnt", int'(bw.cnt), 0);
      chk("reset.rc",  int'(bw.rc),  0);
      chk("reset.ovf", int'(bw.ovf), 0);
      rst = 1'b0;

`ifdef COUNTER_PRESCALE_EN
      ce = 1'b1; s = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         chk("presc.cnt", int'(bw.cnt), k / 4);
      end
      ce = 1'b0;
`else
      begin : up_wrap
         int exp_up [12] = '{1,2,3,4,5,6,7,8,9,0,1,2};
         ce = 1'b1; s = 1'b1;
         for (int i = 0; i < 12; i++) begin
            cyc();
            chk("up.cnt", int'(bw.cnt), exp_up[i]);
            chk("up.rc",  int'(bw.rc),  int'(i == 9));
            chk("up.ovf", int'(bw.ovf), int'(i >= 9));
         end
      end

      ce = 1'b0; load = 1'b1; pdata = 4'd15;
      cyc();
      chk("load_clamp.cnt", int'(bw.cnt), 9);
      chk("load_clamp.tc",  int'(bw.tc),  1);
      chk("load_clamp.ovf", int'(bw.ovf), 1);

      begin : down_wrap
         int exp_dn [10] = '{8,7,6,5,4,3,2,1,0,9};
         load = 1'b0; s = 1'b0; ce = 1'b1;
         for (int i = 0; i < 10; i++) begin
            cyc();
            chk("down.cnt", int'(bw.cnt), exp_dn[i]);
            chk("down.rc",  int'(bw.rc),  int'(i == 9));
         end
      end

      ce = 1'b0; load = 1'b1; pdata = 4'd9;
      cyc();
      load = 1'b0; s = 1'b1; ce = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("sat.hold.cnt", int'(bs.cnt), 9);
         chk("sat.hold.rc",  int'(bs.rc),  1);
         chk("sat.hold.ovf", int'(bs.ovf), 1);
      end
      ce = 1'b0; clr = 1'b1;
      cyc();
      chk("sat.clr.cnt", int'(bs.cnt), 0);
      chk("sat.clr.ovf", int'(bs.ovf), 0);

      ce = 1'b0; clr = 1'b0;
      cyc();
      chk("hold.cnt", int'(bw.cnt), 0);
      chk("hold.rc",  int'(bw.rc),  0);

      load = 1'b1; pdata = 4'd3;
      cyc();
      clr = 1'b1; load = 1'b1; ce = 1'b1; pdata = 4'd5;
      cyc();
      chk("clr_wins.cnt", int'(bw.cnt), 0);
      clr = 1'b0;
      cyc();
      chk("load_wins.cnt", int'(bw.cnt), 5);
      chk("load_wins.rc",  int'(bw.rc),  0);

      pdata = 4'd7; ce = 1'b0;
      cyc();
      load = 1'b0; rst = 1'b1; ce = 1'b1; s = 1'b1;
      cyc();
      chk("rst_mid.cnt", int'(bw.cnt), 0);
      chk("rst_mid.rc",  int'(bw.rc),  0);
      rst = 1'b0;
      cyc();
      chk("after_rst.cnt", int'(bw.cnt), 1);

      // Direction flips on the very edge it is sampled.
      s = 1'b0;
      cyc();
      chk("dir_flip.cnt", int'(bw.cnt), 0);
      cyc();
      chk("dir_flip.wrap", int'(bw.cnt), 9);
      ce = 1'b0;
`endif
      cyc();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
